scnn_input_compressor: RTL and testbench

Upstream stage of `scnn_PE`: consumes a dense, raster-ordered activation stream for one input plane and produces zero-skipped tiles of up to 16 nonzero values. Each tile carries 8-bit dense coordinates, a nonzero count and a base offset, ready to drive the PE's `compressed_inputs`, `comp_indices_ips`, `num_nz_ips` and `offset_ipind` inputs. A plane larger than one tile is emitted as a sequence of tiles under a valid/ready handshake.

---
 rtl/scnn_input_compressor.sv | 117 +++++++++++
 tb/tb_scnn_input_compressor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/scnn_input_compressor.sv
// Zero-skipping compressor: dense raster plane in, tiles of up to TILE_NZ nonzeros out.
// Tile valid the cycle after its closing accept; in_ready is held low while a tile waits on out_ready.
module scnn_input_compressor #(
   parameter int DATA_W  = 16,
   parameter int TILE_NZ = 16,
   parameter int IDX_W   = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [7:0]                       ip_dim,
   input  logic                             in_valid,
   input  logic [DATA_W-1:0]                in_data,
   output logic                             in_ready,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [TILE_NZ-1:0][DATA_W-1:0]   compressed_inputs,
   output logic [TILE_NZ-1:0][IDX_W-1:0]    comp_indices_ips,
   output logic [7:0]                       num_nz_ips,
   output logic [7:0]                       offset_ipind,
   output logic                             last_tile,
   output logic                             done,
   output logic                             err
);
   localparam int SLOT_W = $clog2(TILE_NZ);

   typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;
   state_t state, state_nxt;

   logic [8:0] total;
   logic [8:0] pos;
   logic [8:0] dim9;
   logic       dim_ok;
   logic       accept;
   logic       nz;
   logic       slot_last;
   logic       at_end;

   assign dim9      = {1'b0, ip_dim};
   assign dim_ok    = (ip_dim != 8'd0) && (ip_dim <= 8'd16);
   assign in_ready  = (state == FILL);
   assign out_valid = (state == HOLD);
   assign done      = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign nz        = (in_data != '0);
   assign slot_last = nz && (num_nz_ips == 8'(TILE_NZ - 1));
   assign at_end    = (pos == total - 9'd1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && dim_ok) state_nxt = FILL;
         FILL:    if (accept && (slot_last || at_end)) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = last_tile ? DONE : FILL;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         total             <= '0;
         pos               <= '0;
         compressed_inputs <= '0;
         comp_indices_ips  <= '0;
         num_nz_ips        <= '0;
         offset_ipind      <= '0;
         last_tile         <= 1'b0;
         err               <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (dim_ok) begin
                     total             <= dim9 * dim9;
                     pos               <= '0;
                     compressed_inputs <= '0;
                     comp_indices_ips  <= '0;
                     num_nz_ips        <= '0;
                     offset_ipind      <= '0;
                     last_tile         <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (accept) begin
                  pos <= pos + 9'd1;
                  if (nz) begin
                     compressed_inputs[num_nz_ips[SLOT_W-1:0]] <= in_data;
                     comp_indices_ips[num_nz_ips[SLOT_W-1:0]]  <= IDX_W'(pos);
                     num_nz_ips                                <= num_nz_ips + 8'd1;
                  end
                  if (at_end) last_tile <= 1'b1;
               end
            end
            HOLD: begin
               // Unused slots must read zero: the PE fetches in groups of 4 past num_nz.
               if (out_ready && !last_tile) begin
                  compressed_inputs <= '0;
                  comp_indices_ips  <= '0;
                  num_nz_ips        <= '0;
                  offset_ipind      <= pos[7:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_scnn_input_compressor.sv
// Directed bench for scnn_input_compressor: table of planes with hand-computed tile shapes plus error/reset sequences.
module tb_scnn_input_compressor;
   localparam int DW = 16;
   localparam int NZ = 16;
   localparam int IW = 8;

   logic clk = 1'b0;
   logic rst, start, in_valid, out_ready;
   logic in_ready, out_valid, last_tile, done, err;
   logic [7:0] ip_dim, num_nz_ips, offset_ipind;
   logic [DW-1:0] in_data;
   logic [NZ-1:0][DW-1:0] compressed_inputs;
   logic [NZ-1:0][IW-1:0] comp_indices_ips;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   scnn_input_compressor #(.DATA_W(DW), .TILE_NZ(NZ), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .ip_dim(ip_dim),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .compressed_inputs(compressed_inputs), .comp_indices_ips(comp_indices_ips),
      .num_nz_ips(num_nz_ips), .offset_ipind(offset_ipind),
      .last_tile(last_tile), .done(done), .err(err)
   );

   typedef struct {
      int dim;
      int pat;
      bit stall;
      int ntiles;
      int nz0;
      int nz1;
      int off0;
      int off1;
   } rec_t;

   rec_t tbl [6];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Dense stimulus patterns, indexed by raster position.
   function automatic int gen(input int pat, input int p);
      case (pat)
         0:       return 0;
         1:       return 1;
         2:       return (p == 1) ? 5 : (p == 4) ? 7 : (p == 8) ? 9 : 0;
         3:       return (p < 16) ? p + 3 : 0;
         default: return 3 * p + 1;
      endcase
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_last"}, int'(last_tile), 0);
      chk({tag, "_num_nz"}, int'(num_nz_ips), 0);
      chk({tag, "_offset"}, int'(offset_ipind), 0);
      chk({tag, "_vals_zero"}, int'(compressed_inputs == '0), 1);
      chk({tag, "_idx_zero"}, int'(comp_indices_ips == '0), 1);
   endtask

   task automatic run_plane(input rec_t r, input string tag);
      int total, p, tile, qi, hold, cyc, en, eo, ev, ei;
      bit fin, acc, hs, was_last;
      int mv[$];
      int mi[$];
      logic [NZ-1:0][DW-1:0] sv;
      logic [NZ-1:0][IW-1:0] si;
      logic [7:0] sn, so;
      logic sl;
      total = r.dim * r.dim;
      p = 0; tile = 0; qi = 0; hold = 0; cyc = 0; fin = 1'b0;
      sv = '0; si = '0; sn = '0; so = '0; sl = 1'b0;
      for (int i = 0; i < total; i++) begin
         if (gen(r.pat, i) != 0) begin
            mv.push_back(gen(r.pat, i));
            mi.push_back(i);
         end
      end
      ip_dim = 8'(r.dim);
      start = 1'b1;
      tick();
      start = 1'b0;
      ip_dim = 8'd0;
      chk({tag, "_start_rdy"}, int'(in_ready), 1);
      while (!fin) begin
         cyc++;
         if (cyc > 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d tiles, expected %0d", tag, tile, r.ntiles);
            break;
         end
         if (out_valid) begin
            if (hold == 0) begin
               en = (tile == 0) ? r.nz0 : r.nz1;
               eo = (tile == 0) ? r.off0 : r.off1;
               if (tile >= r.ntiles) chk({tag, "_extra_tile"}, tile, r.ntiles - 1);
               chk($sformatf("%s_t%0d_num_nz", tag, tile), int'(num_nz_ips), en);
               chk($sformatf("%s_t%0d_offset", tag, tile), int'(offset_ipind), eo);
               chk($sformatf("%s_t%0d_last", tag, tile), int'(last_tile), int'(tile == r.ntiles - 1));
               chk($sformatf("%s_t%0d_hold_rdy", tag, tile), int'(in_ready), 0);
               for (int k = 0; k < NZ; k++) begin
                  ev = 0;
                  ei = 0;
                  if (k < en && qi + k < mv.size()) begin
                     ev = mv[qi + k];
                     ei = mi[qi + k];
                  end
                  chk($sformatf("%s_t%0d_val%0d", tag, tile, k), int'(compressed_inputs[k]), ev);
                  chk($sformatf("%s_t%0d_idx%0d", tag, tile, k), int'(comp_indices_ips[k]), ei);
               end
               qi += en;
               sv = compressed_inputs; si = comp_indices_ips;
               sn = num_nz_ips; so = offset_ipind; sl = last_tile;
            end else begin
               chk($sformatf("%s_t%0d_stable", tag, tile),
                   int'(compressed_inputs == sv && comp_indices_ips == si && num_nz_ips == sn &&
                        offset_ipind == so && last_tile == sl && !in_ready), 1);
            end
            hold++;
            out_ready = !r.stall || hold > 10;
         end else begin
            out_ready = 1'b0;
         end
         in_valid = (p < total) && (r.stall ? ($urandom_range(0, 1) == 1) : 1'b1);
         in_data  = in_valid ? 16'(gen(r.pat, p)) : 16'($urandom);
         acc = in_valid && in_ready;
         hs = out_valid && out_ready;
         was_last = last_tile;
         tick();
         if (acc) begin
            p++;
            if (p == total) chk({tag, "_flush_lat"}, int'(out_valid), 1);
         end
         if (hs) begin
            tile++;
            hold = 0;
            out_ready = 1'b0;
            if (was_last) begin
               chk({tag, "_done"}, int'(done), 1);
               chk({tag, "_valid_drop"}, int'(out_valid), 0);
               tick();
               chk({tag, "_idle_rdy"}, int'(in_ready), 0);
               chk({tag, "_done_pulse"}, int'(done), 0);
               fin = 1'b1;
            end else begin
               chk($sformatf("%s_t%0d_resume_rdy", tag, tile), int'(in_ready), 1);
               chk($sformatf("%s_t%0d_valid_drop", tag, tile), int'(out_valid), 0);
            end
         end
      end
      in_valid = 1'b0;
      chk({tag, "_tiles"}, tile, r.ntiles);
      chk({tag, "_elems"}, p, total);
      chk({tag, "_nz_consumed"}, qi, mv.size());
   endtask

   initial begin
      tbl[0] = '{dim:4, pat:0, stall:1'b0, ntiles:1, nz0:0,  nz1:0, off0:0, off1:0};
      tbl[1] = '{dim:3, pat:2, stall:1'b0, ntiles:1, nz0:3,  nz1:0, off0:0, off1:0};
      tbl[2] = '{dim:5, pat:1, stall:1'b0, ntiles:2, nz0:16, nz1:9, off0:0, off1:16};
      tbl[3] = '{dim:5, pat:4, stall:1'b1, ntiles:2, nz0:16, nz1:9, off0:0, off1:16};
      tbl[4] = '{dim:4, pat:4, stall:1'b0, ntiles:1, nz0:16, nz1:0, off0:0, off1:0};
      tbl[5] = '{dim:5, pat:3, stall:1'b0, ntiles:2, nz0:16, nz1:0, off0:0, off1:16};

      rst = 1'b1; start = 1'b0; ip_dim = 8'd0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick(); tick();
      check_reset("por");
      rst = 1'b0;
      tick();

      for (int d = 0; d < 2; d++) begin
         ip_dim = (d == 0) ? 8'd0 : 8'd17;
         start = 1'b1;
         tick();
         start = 1'b0;
         chk($sformatf("err_dim%0d_pulse", ip_dim), int'(err), 1);
         chk($sformatf("err_dim%0d_idle", ip_dim), int'(in_ready), 0);
         tick();
         chk($sformatf("err_dim%0d_clear", ip_dim), int'(err), 0);
         chk($sformatf("err_dim%0d_still_idle", ip_dim), int'(in_ready), 0);
      end

      for (int i = 0; i < 6; i++) run_plane(tbl[i], $sformatf("row%0d", i));

      // Abort a plane after 7 accepts; a bad start mid-plane must not raise err.
      ip_dim = 8'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_data = 16'(9 + k);
         start = (k == 3);
         ip_dim = (k == 3) ? 8'd0 : 8'd4;
         tick();
         start = 1'b0;
         if (k == 3) chk("busy_start_no_err", int'(err), 0);
      end
      chk("abort_num_nz_before_rst", int'(num_nz_ips), 7);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check_reset("abort");
      rst = 1'b0;
      tick();
      chk("abort_needs_start", int'(in_ready), 0);
      run_plane(tbl[1], "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
